// File: rtl/hazard_pkg.sv
// Shared types and sizes for the hazard scoreboard controller.
package hazard_pkg;

    localparam int NREG = 16;
    localparam int RW   = 4;
    localparam int CW   = 2;

    typedef logic [RW-1:0] reg_idx_t;
    typedef logic [2:0]    src_mask_t;

    typedef enum logic {
        RF_SCALAR = 1'b0,
        RF_VECTOR = 1'b1
    } rfile_e;

    // Which of the pipeline-control actions is in effect this cycle.
    typedef enum logic [1:0] {
        CTL_RUN   = 2'd0,
        CTL_STALL = 2'd1,
        CTL_FLUSH = 2'd2,
        CTL_RESET = 2'd3
    } ctl_mode_e;

endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// ID/EX/WB side-band bundle and pipeline control outputs of the scoreboard.
//
// Handshake: id_valid says ID holds a real instruction; id_issue is asserted
// in the same cycle exactly when that instruction advances to EX. An
// instruction with id_valid=1 and id_issue=0 must be presented again next
// cycle (IF/ID holds) unless it is flushed by a taken jump.
interface hazard_scoreboard_ctrl_if;
    import hazard_pkg::*;

    logic      id_valid;
    reg_idx_t  id_rs1;
    reg_idx_t  id_rs2;
    reg_idx_t  id_rs3;
    src_mask_t id_use;
    src_mask_t id_src_vec;
    logic      id_regswrite;
    logic      id_regvwrite;
    logic      ex_pc_src;
    logic      wb_regswrite;
    logic      wb_regvwrite;
    reg_idx_t  wb_rd;

    logic      pc_load;
    logic      ifid_hold;
    logic      ifid_flush;
    logic      idex_flush;
    logic      id_issue;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs3, id_use, id_src_vec,
               id_regswrite, id_regvwrite, ex_pc_src,
               wb_regswrite, wb_regvwrite, wb_rd,
        input  pc_load, ifid_hold, ifid_flush, idex_flush, id_issue
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs3, id_use, id_src_vec,
               id_regswrite, id_regvwrite, ex_pc_src,
               wb_regswrite, wb_regvwrite, wb_rd,
        output pc_load, ifid_hold, ifid_flush, idex_flush, id_issue
    );

endinterface

// File: rtl/sb_counter_bank.sv
// One register file's pending-write counters with per-source pending lookup.
module sb_counter_bank
    import hazard_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc_i,
    input  reg_idx_t           inc_idx_i,
    input  logic               dec_i,
    input  reg_idx_t           dec_idx_i,
    input  logic [2:0][RW-1:0] rd_idx_i,
    output logic [2:0]         pend_o,
    output logic               ovf_o,
    output logic               unf_o
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];

    // Next counter values; an inc and dec hitting the same entry cancel out.
    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        unf_o = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (inc_i && (inc_idx_i == RW'(i)) && !(dec_i && (dec_idx_i == RW'(i)))) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_o = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else if (dec_i && (dec_idx_i == RW'(i)) && !(inc_i && (inc_idx_i == RW'(i)))) begin
                if (cnt_q[i] == '0) begin
                    unf_o = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end
            end
        end
    end

    // Pending lookup; with write-through, the last write retiring now is not pending.
    always_comb begin
        pend_o = '0;
        for (int k = 0; k < 3; k++) begin
            pend_o[k] = (cnt_q[rd_idx_i[k]] != '0) &&
                        !(WB_BYPASS && dec_i && (dec_idx_i == rd_idx_i[k]) &&
                          (cnt_q[rd_idx_i[k]] == CW'(1)));
        end
    end

    // Counter storage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Pipeline sequencing controller: RAW stall in ID, taken-jump flush from EX,
// saturating perf counters and sticky scoreboard error flags.
module hazard_scoreboard_ctrl
    import hazard_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b0,
    parameter int PERF_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    hazard_scoreboard_ctrl_if.slave bus,
    output logic [PERF_W-1:0]       stall_cycles,
    output logic [PERF_W-1:0]       flush_count,
    output logic                    err_overflow,
    output logic                    err_underflow,
    output ctl_mode_e               dbg_mode_o
);

    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    logic [2:0]         s_pend;
    logic [2:0]         v_pend;
    logic [2:0]         src_pend;
    logic [2:0][RW-1:0] rd_idx;
    logic               hazard;
    logic               issue;
    logic               s_ovf, s_unf, v_ovf, v_unf;
    ctl_mode_e          mode;

    logic [PERF_W-1:0]  stall_q, stall_d;
    logic [PERF_W-1:0]  flush_q, flush_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_unf_q, err_unf_d;

    // rs1 doubles as the destination index.
    assign rd_idx = {bus.id_rs3, bus.id_rs2, bus.id_rs1};

    sb_counter_bank #(.WB_BYPASS(WB_BYPASS)) u_scalar (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (issue && bus.id_regswrite),
        .inc_idx_i (bus.id_rs1),
        .dec_i     (bus.wb_regswrite),
        .dec_idx_i (bus.wb_rd),
        .rd_idx_i  (rd_idx),
        .pend_o    (s_pend),
        .ovf_o     (s_ovf),
        .unf_o     (s_unf)
    );

    sb_counter_bank #(.WB_BYPASS(WB_BYPASS)) u_vector (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (issue && bus.id_regvwrite),
        .inc_idx_i (bus.id_rs1),
        .dec_i     (bus.wb_regvwrite),
        .dec_idx_i (bus.wb_rd),
        .rd_idx_i  (rd_idx),
        .pend_o    (v_pend),
        .ovf_o     (v_ovf),
        .unf_o     (v_unf)
    );

    // RAW hazard: any used source whose selected file has a write in flight.
    always_comb begin
        src_pend = '0;
        for (int k = 0; k < 3; k++) begin
            src_pend[k] = (rfile_e'(bus.id_src_vec[k]) == RF_VECTOR) ? v_pend[k] : s_pend[k];
        end
        hazard = bus.id_valid && |(bus.id_use & src_pend);
    end

    // Control mode by priority: reset, taken jump, hazard, run.
    always_comb begin
        mode = CTL_RUN;
        if (rst) begin
            mode = CTL_RESET;
        end else if (bus.ex_pc_src) begin
            mode = CTL_FLUSH;
        end else if (hazard) begin
            mode = CTL_STALL;
        end
    end

    // Pipeline control outputs decoded from the mode.
    always_comb begin
        bus.pc_load    = 1'b1;
        bus.ifid_hold  = 1'b0;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        issue          = 1'b0;
        case (mode)
            CTL_RESET: begin
                bus.idex_flush = 1'b1;
            end
            CTL_FLUSH: begin
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end
            CTL_STALL: begin
                bus.pc_load    = 1'b0;
                bus.ifid_hold  = 1'b1;
                bus.idex_flush = 1'b1;
            end
            default: begin
                issue = bus.id_valid;
            end
        endcase
        bus.id_issue = issue;
    end

    // Saturating perf counters and sticky error flags.
    always_comb begin
        stall_d   = stall_q;
        flush_d   = flush_q;
        err_ovf_d = err_ovf_q | s_ovf | v_ovf;
        err_unf_d = err_unf_q | s_unf | v_unf;
        if ((mode == CTL_STALL) && (stall_q != PERF_MAX)) begin
            stall_d = stall_q + PERF_W'(1);
        end
        if ((mode == CTL_FLUSH) && (flush_q != PERF_MAX)) begin
            flush_d = flush_q + PERF_W'(1);
        end
    end

    // Status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q   <= '0;
            flush_q   <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign flush_count   = flush_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;
    assign dbg_mode_o    = mode;

endmodule
